// File: rtl/difftest_step_pkg.sv
package difftest_step_pkg;

  localparam int unsigned STEP_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic int unsigned core_id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/difftest_step_rr_arbiter.sv
module difftest_step_rr_arbiter
  import difftest_step_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 2,
  localparam int unsigned CW        = core_id_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] elig,
  input  logic [CW-1:0]        rr_ptr,
  output logic [CW-1:0]        grant,
  output logic                 any_grant
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= NUM_CORES; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_CORES;
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
        if (!any_grant && (j == idx) && elig[j]) begin
          any_grant = 1'b1;
          grant     = CW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/difftest_step_scheduler.sv
module difftest_step_scheduler
  import difftest_step_pkg::*;
#(
  parameter  int unsigned NUM_CORES       = 2,
  parameter  int unsigned STEP_WIDTH      = STEP_WIDTH_DEFAULT,
  parameter  int unsigned ACC_WIDTH       = 16,
  parameter  int unsigned BATCH_THRESHOLD = 64,
  parameter  int unsigned FLUSH_CYCLES    = 4999,
  localparam int unsigned CW              = core_id_width(NUM_CORES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] in_step,
  input  logic                            stop,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CW-1:0]                   out_core,
  output logic [STEP_WIDTH-1:0]           out_step,
  output logic                            pending,
  output logic                            overflow
);

  localparam int unsigned TW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [TW-1:0]        TIMER_MAX = TW'(FLUSH_CYCLES);
  localparam logic [ACC_WIDTH-1:0] THR       = ACC_WIDTH'(BATCH_THRESHOLD);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;
  localparam logic [ACC_WIDTH-1:0] STEP_MAX  = {{(ACC_WIDTH-STEP_WIDTH){1'b0}}, {STEP_WIDTH{1'b1}}};

  state_e                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           out_core_q, out_core_d;
  logic [STEP_WIDTH-1:0]   out_step_q, out_step_d;
  logic                    pending_q, pending_d;
  logic                    overflow_q, overflow_d;
  logic [ACC_WIDTH-1:0]    acc_q [NUM_CORES];
  logic [ACC_WIDTH-1:0]    acc_d [NUM_CORES];
  logic [TW-1:0]           timer_q, timer_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [CW-1:0]           rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0]    elig;
  logic [CW-1:0]           grant;
  logic                    any_grant;
  logic                    load;
  logic [ACC_WIDTH-1:0]    sel_acc;
  logic [STEP_WIDTH-1:0]   load_step;
  logic [ACC_WIDTH:0]      sum [NUM_CORES];
  logic                    flush_wrap;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      elig[i] = (acc_q[i] >= THR) | (flush_pending_q & (acc_q[i] != '0));
    end
  end

  difftest_step_rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .elig      (elig),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_acc = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant == CW'(i)) sel_acc = acc_q[i];
    end
    load_step = (sel_acc > STEP_MAX) ? '1 : sel_acc[STEP_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_core_d  = out_core_q;
    out_step_d  = out_step_q;
    rr_ptr_d    = rr_ptr_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = HALT;
        end else if (any_grant) begin
          load        = 1'b1;
          out_valid_d = 1'b1;
          out_core_d  = grant;
          out_step_d  = load_step;
          rr_ptr_d    = grant;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = stop ? HALT : IDLE;
        end
      end
      HALT: begin
        out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // The amount loaded into the output register leaves the accumulator in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    pending_d  = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      sum[i] = {1'b0, acc_q[i]}
             - ((load && (grant == CW'(i))) ? {{(ACC_WIDTH-STEP_WIDTH+1){1'b0}}, load_step} : '0)
             + {{(ACC_WIDTH-STEP_WIDTH+1){1'b0}}, in_step[i*STEP_WIDTH +: STEP_WIDTH]};
      if (sum[i][ACC_WIDTH]) begin
        acc_d[i]   = ACC_MAX;
        overflow_d = 1'b1;
      end else begin
        acc_d[i] = sum[i][ACC_WIDTH-1:0];
      end
      if (acc_d[i] != '0) pending_d = 1'b1;
    end
  end

  always_comb begin
    flush_wrap      = (timer_q == TIMER_MAX);
    timer_d         = flush_wrap ? '0 : timer_q + TW'(1);
    flush_pending_d = flush_wrap ? 1'b1 : (pending_d ? flush_pending_q : 1'b0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      out_valid_q     <= 1'b0;
      out_core_q      <= '0;
      out_step_q      <= '0;
      pending_q       <= 1'b0;
      overflow_q      <= 1'b0;
      timer_q         <= '0;
      flush_pending_q <= 1'b0;
      rr_ptr_q        <= CW'(NUM_CORES - 1);
      for (int unsigned i = 0; i < NUM_CORES; i++) acc_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      out_core_q      <= out_core_d;
      out_step_q      <= out_step_d;
      pending_q       <= pending_d;
      overflow_q      <= overflow_d;
      timer_q         <= timer_d;
      flush_pending_q <= flush_pending_d;
      rr_ptr_q        <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_CORES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_core  = out_core_q;
  assign out_step  = out_step_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
module tb_difftest_step_scheduler;

  localparam int NC   = 2;
  localparam int SW   = 8;
  localparam int AW   = 16;
  localparam int THR  = 64;
  localparam int FL   = 40;
  localparam int AMAX = (1 << AW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NC*SW-1:0] in_step = '0;
  logic             stop = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [0:0]       out_core;
  logic [SW-1:0]    out_step;
  logic             pending;
  logic             overflow;

  difftest_step_scheduler #(
    .NUM_CORES       (NC),
    .STEP_WIDTH      (SW),
    .ACC_WIDTH       (AW),
    .BATCH_THRESHOLD (THR),
    .FLUSH_CYCLES    (FL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_step   (in_step),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_core  (out_core),
    .out_step  (out_step),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // reference model: current and next state
  int m_acc [NC];
  int n_acc [NC];
  int m_timer, n_timer, m_rr, n_rr, m_core, n_core, m_step, n_step;
  bit m_flush, n_flush, m_valid, n_valid, m_halt, n_halt, m_pend, n_pend, m_ovf, n_ovf;

  function automatic void chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
  endfunction

  function automatic void model_next(input int i0, input int i1, input bit st, input bit rdy);
    int inc [NC];
    int ded [NC];
    int a;
    bit any_nz;
    inc[0] = i0;
    inc[1] = i1;
    for (int i = 0; i < NC; i++) ded[i] = 0;
    n_valid = m_valid; n_core = m_core; n_step = m_step;
    n_rr = m_rr; n_halt = m_halt; n_ovf = m_ovf;
    if (m_halt) begin
      n_valid = 0;
    end else if (m_valid) begin
      if (rdy) begin
        n_valid = 0;
        n_halt  = st;
      end
    end else if (st) begin
      n_halt = 1;
    end else begin
      for (int k = 1; k <= NC; k++) begin
        int c;
        c = (m_rr + k) % NC;
        if (m_acc[c] >= THR || (m_flush && m_acc[c] > 0)) begin
          n_core  = c;
          n_step  = (m_acc[c] > SMAX) ? SMAX : m_acc[c];
          ded[c]  = n_step;
          n_valid = 1;
          n_rr    = c;
          break;
        end
      end
    end
    any_nz = 0;
    for (int i = 0; i < NC; i++) begin
      a = m_acc[i] - ded[i] + inc[i];
      if (a > AMAX) begin
        a = AMAX;
        n_ovf = 1;
      end
      n_acc[i] = a;
      if (a != 0) any_nz = 1;
    end
    n_pend = any_nz;
    if (m_timer == FL) begin
      n_timer = 0;
      n_flush = 1;
    end else begin
      n_timer = m_timer + 1;
      n_flush = any_nz ? m_flush : 0;
    end
  endfunction

  task automatic tick(input int i0, input int i1, input bit st, input bit rdy);
    reset     = 1'b0;
    in_step   = {SW'(i1), SW'(i0)};
    stop      = st;
    out_ready = rdy;
    model_next(i0, i1, st, rdy);
    @(posedge clock);
    #1;
    for (int i = 0; i < NC; i++) m_acc[i] = n_acc[i];
    m_timer = n_timer; m_rr = n_rr; m_core = n_core; m_step = n_step;
    m_flush = n_flush; m_valid = n_valid; m_halt = n_halt; m_pend = n_pend; m_ovf = n_ovf;
    cyc++;
    chk("model_valid", int'(out_valid), int'(m_valid));
    chk("model_pending", int'(pending), int'(m_pend));
    chk("model_overflow", int'(overflow), int'(m_ovf));
    if (m_valid) begin
      chk("model_core", int'(out_core), m_core);
      chk("model_step", int'(out_step), m_step);
    end
  endtask

  task automatic tick_reset();
    reset     = 1'b1;
    in_step   = '0;
    stop      = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NC; i++) m_acc[i] = 0;
    m_timer = 0; m_rr = NC - 1; m_core = 0; m_step = 0;
    m_flush = 0; m_valid = 0; m_halt = 0; m_pend = 0; m_ovf = 0;
    cyc = 0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_core", int'(out_core), 0);
    chk("rst_step", int'(out_step), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
  endtask

  typedef struct {
    bit rst;
    int i0;
    int i1;
    bit st;
    bit rdy;
    bit ev;
    int ec;
    int es;
    bit ep;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input bit rst, input int i0, input int i1, input bit st, input bit rdy,
                              input bit ev, input int ec, input int es, input bit ep);
    vec_t v;
    v.rst = rst; v.i0 = i0; v.i1 = i1; v.st = st; v.rdy = rdy;
    v.ev = ev; v.ec = ec; v.es = es; v.ep = ep;
    return v;
  endfunction

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // single core reaching threshold
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 16, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 16, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 16, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 64, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // simultaneous eligibility, round robin
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64, 64, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 64, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 64, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64, 64, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 64, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 64, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      if (tbl[k].rst) tick_reset();
      else tick(tbl[k].i0, tbl[k].i1, tbl[k].st, tbl[k].rdy);
      chk("tbl_valid", int'(out_valid), int'(tbl[k].ev));
      chk("tbl_pending", int'(pending), int'(tbl[k].ep));
      if (tbl[k].ev) begin
        chk("tbl_core", int'(out_core), tbl[k].ec);
        chk("tbl_step", int'(out_step), tbl[k].es);
      end
    end

    // flush of a sub-threshold residue
    tick_reset();
    tick(0, 5, 0, 1);
    while (!out_valid && cyc < 60) tick(0, 0, 0, 1);
    chk("flush_issue_cycle", cyc, 42);
    chk("flush_valid", int'(out_valid), 1);
    chk("flush_core", int'(out_core), 1);
    chk("flush_step", int'(out_step), 5);
    tick(0, 0, 0, 1);
    chk("flush_accept", int'(out_valid), 0);
    tick(3, 0, 0, 1);
    for (int k = 0; k < 25; k++) begin
      tick(0, 0, 0, 1);
      chk("flush_cleared", int'(out_valid), 0);
    end

    // clamp to step width, residue waits for flush
    tick_reset();
    tick(255, 0, 0, 0);
    tick(45, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("clamp_valid", int'(out_valid), 1);
    chk("clamp_step", int'(out_step), 255);
    chk("clamp_pending", int'(pending), 1);
    tick(0, 0, 0, 1);
    chk("clamp_accept", int'(out_valid), 0);
    while (!out_valid && cyc < 60) tick(0, 0, 0, 1);
    chk("residue_cycle", cyc, 42);
    chk("residue_step", int'(out_step), 45);
    tick(0, 0, 0, 1);
    chk("residue_pending", int'(pending), 0);

    // backpressure holds the command while accumulation continues
    tick_reset();
    tick(64, 0, 0, 0);
    tick(10, 0, 0, 0);
    chk("stall_start", int'(out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      tick(10, 0, 0, 0);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_core", int'(out_core), 0);
      chk("stall_step", int'(out_step), 64);
    end
    tick(0, 0, 0, 1);
    chk("stall_accept", int'(out_valid), 0);
    tick(0, 0, 0, 1);
    chk("stall_next_valid", int'(out_valid), 1);
    chk("stall_next_step", int'(out_step), 110);
    tick(0, 0, 0, 1);

    // stop during an in-flight command
    tick_reset();
    tick(64, 0, 0, 0);
    tick(70, 0, 0, 0);
    tick(0, 0, 1, 0);
    chk("stop_keeps_cmd", int'(out_valid), 1);
    tick(0, 0, 1, 1);
    chk("stop_accept", int'(out_valid), 0);
    for (int k = 0; k < 20; k++) begin
      tick(3, 2, 0, 1);
      chk("halt_valid", int'(out_valid), 0);
      chk("halt_pending", int'(pending), 1);
    end

    // accumulator saturation while halted
    tick_reset();
    for (int k = 0; k < 257; k++) tick(255, 0, 1, 1);
    chk("sat_edge_no_ovf", int'(overflow), 0);
    tick(255, 0, 1, 1);
    chk("sat_ovf", int'(overflow), 1);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 1);
      chk("sat_ovf_sticky", int'(overflow), 1);
      chk("sat_no_issue", int'(out_valid), 0);
    end

    // randomized traffic against the model
    for (int seg = 0; seg < 2; seg++) begin
      tick_reset();
      for (int k = 0; k < 3000; k++) begin
        int r0, r1;
        bit rdy, st;
        r0  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
        r1  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
        rdy = ($urandom_range(0, 3) != 0);
        st  = (seg == 1) && ($urandom_range(0, 1999) == 0);
        tick(r0, r1, st, rdy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
